// File: rtl/wrapper_ahb_stream_bridge_if.sv
// AHB-Lite target-side signal bundle for the streaming-engine bridge.
interface wrapper_ahb_stream_bridge_if #(
    parameter int unsigned AHBADDRWIDTH = 12
) ();
    logic                    HSELS;
    logic [AHBADDRWIDTH-1:0] HADDRS;
    logic [1:0]              HTRANSS;
    logic [2:0]              HSIZES;
    logic                    HWRITES;
    logic                    HREADYS;
    logic [31:0]             HWDATAS;
    logic                    HREADYOUTS;
    logic                    HRESPS;
    logic [31:0]             HRDATAS;

    modport slave (
        input  HSELS, HADDRS, HTRANSS, HSIZES, HWRITES, HREADYS, HWDATAS,
        output HREADYOUTS, HRESPS, HRDATAS
    );

    modport master (
        output HSELS, HADDRS, HTRANSS, HSIZES, HWRITES, HREADYS, HWDATAS,
        input  HREADYOUTS, HRESPS, HRDATAS
    );
endinterface

// File: rtl/wrapper_ahb_stream_bridge.sv
// AHB-Lite to valid/ready bridge: input packet buffer, config channel from control registers,
// output packet FIFO and registered DMA requests.
module wrapper_ahb_stream_bridge #(
    parameter int unsigned AHBADDRWIDTH   = 12,
    parameter int unsigned INPACKETWIDTH  = 512,
    parameter int unsigned OUTPACKETWIDTH = 256,
    parameter int unsigned CFGSIZEWIDTH   = 64,
    parameter int unsigned CFGSCHEMEWIDTH = 2,
    parameter int unsigned OUTFIFODEPTH   = 2
) (
    input  logic                          HCLK,
    input  logic                          HRESET,
    wrapper_ahb_stream_bridge_if.slave    ahb,
    output logic [INPACKETWIDTH-1:0]      in_data,
    output logic                          in_last,
    output logic                          in_valid,
    input  logic                          in_ready,
    output logic [CFGSIZEWIDTH-1:0]       cfg_size,
    output logic [CFGSCHEMEWIDTH-1:0]     cfg_scheme,
    output logic                          cfg_last,
    output logic                          cfg_valid,
    input  logic                          cfg_ready,
    input  logic [OUTPACKETWIDTH-1:0]     out_data,
    input  logic                          out_last,
    input  logic                          out_valid,
    output logic                          out_ready,
    output logic                          in_data_req,
    output logic                          out_data_req
);
    localparam int unsigned AW       = AHBADDRWIDTH;
    localparam int unsigned InWords  = INPACKETWIDTH / 32;
    localparam int unsigned OutWords = OUTPACKETWIDTH / 32;
    localparam int unsigned PtrW     = $clog2(OUTFIFODEPTH);
    localparam int unsigned CntW     = PtrW + 1;
    localparam int unsigned EntW     = OUTPACKETWIDTH + 1;

    typedef enum logic [1:0] {StOk, StErr1, StErr2} resp_st_e;

    resp_st_e                  state_q, state_d;
    logic [AW-1:0]             dp_addr_q, dp_addr_d;
    logic                      dp_wr_q, dp_wr_d;
    logic [31:0]               rdata_q, rdata_d;
    logic [INPACKETWIDTH-1:0]  in_data_q, in_data_d;
    logic                      in_valid_q, in_valid_d, in_last_q, in_last_d;
    logic [CFGSIZEWIDTH-1:0]   size_sh_q, size_sh_d, cfg_size_q, cfg_size_d;
    logic [CFGSCHEMEWIDTH-1:0] scheme_sh_q, scheme_sh_d, cfg_scheme_q, cfg_scheme_d;
    logic                      cfg_last_q, cfg_last_d, cfg_valid_q, cfg_valid_d;
    logic                      in_req_en_q, in_req_en_d, out_req_en_q, out_req_en_d;
    logic                      in_req_q, in_req_d, out_req_q, out_req_d;
    logic [EntW-1:0]           fifo_q [OUTFIFODEPTH];
    logic [EntW-1:0]           fifo_d [OUTFIFODEPTH];
    logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]           count_q, count_d;

    logic            accept, bad, pop, push, empty, full, stall, hready, hresp;
    logic [EntW-1:0] head;
    logic [1:0]      dp_win;
    int unsigned     off, rd_idx, dp_off, dp_idx;

    assign empty = (count_q == '0);
    assign full  = (count_q == CntW'(OUTFIFODEPTH));
    assign head  = fifo_q[rd_ptr_q];
    assign push  = out_valid && !full;

    // Address-phase decode; errors are decided here so the data phase never changes state.
    always_comb begin
        accept = ahb.HSELS && ahb.HREADYS && ahb.HTRANSS[1];
        bad    = (ahb.HSIZES != 3'b010) || (ahb.HADDRS[1:0] != 2'b00) ||
                 (ahb.HADDRS[AW-1] && (ahb.HWRITES || empty));
    end

    // Data-phase stall: buffer/shadow writes wait until the engine has taken the pending item.
    always_comb begin
        dp_win = dp_addr_q[AW-1:AW-2];
        dp_off = 32'(dp_addr_q[AW-3:0]);
        stall  = 1'b0;
        if (dp_wr_q) begin
            if (dp_win == 2'b00) begin
                stall = in_valid_q;
            end else if (dp_win == 2'b01) begin
                stall = cfg_valid_q &&
                        ((dp_off < 32'h0C) || ((dp_off == 32'h0C) && ahb.HWDATAS[0]));
            end
        end
    end

    always_comb begin
        state_d = StOk;
        if (state_q == StErr1) begin
            state_d = StErr2;
        end else if (accept && bad) begin
            state_d = StErr1;
        end
        hready = (state_q != StErr1) && !stall;
        hresp  = (state_q != StOk);
    end

    // Read data and FIFO pop are taken from state at the address phase.
    always_comb begin
        rdata_d = '0;
        pop     = 1'b0;
        off     = 32'(ahb.HADDRS[AW-3:0]);
        rd_idx  = 32'(ahb.HADDRS[AW-3:2]) % OutWords;
        if (accept && !bad && !ahb.HWRITES) begin
            case (ahb.HADDRS[AW-1:AW-2])
                2'b00: ;
                2'b01: begin
                    case (off)
                        32'h00: rdata_d = size_sh_q[31:0];
                        32'h04: rdata_d[CFGSIZEWIDTH-33:0] = size_sh_q[CFGSIZEWIDTH-1:32];
                        32'h08: rdata_d[CFGSCHEMEWIDTH-1:0] = scheme_sh_q;
                        32'h0C: rdata_d[3:2] = {out_req_en_q, in_req_en_q};
                        32'h10: begin
                            rdata_d[3:0]  = {full, empty, cfg_valid_q, in_valid_q};
                            rdata_d[12:8] = 5'(count_q);
                        end
                        32'h14: rdata_d[0] = !empty && head[OUTPACKETWIDTH];
                        default: ;
                    endcase
                end
                default: begin
                    for (int unsigned w = 0; w < OutWords; w++) begin
                        if (w == rd_idx) rdata_d = head[w*32 +: 32];
                    end
                    pop = (rd_idx == OutWords - 1);
                end
            endcase
        end
    end

    always_comb begin
        dp_wr_d      = dp_wr_q;
        dp_addr_d    = dp_addr_q;
        if (!stall) begin
            dp_wr_d   = accept && !bad && ahb.HWRITES;
            dp_addr_d = ahb.HADDRS;
        end
        in_data_d    = in_data_q;
        in_valid_d   = in_valid_q && !in_ready;
        in_last_d    = in_last_q;
        size_sh_d    = size_sh_q;
        scheme_sh_d  = scheme_sh_q;
        cfg_size_d   = cfg_size_q;
        cfg_scheme_d = cfg_scheme_q;
        cfg_last_d   = cfg_last_q;
        cfg_valid_d  = cfg_valid_q && !cfg_ready;
        in_req_en_d  = in_req_en_q;
        out_req_en_d = out_req_en_q;
        dp_idx       = 32'(dp_addr_q[AW-3:2]) % InWords;
        if (dp_wr_q && !stall) begin
            case (dp_win)
                2'b00: begin
                    for (int unsigned w = 0; w < InWords; w++) begin
                        if (w == dp_idx) in_data_d[w*32 +: 32] = ahb.HWDATAS;
                    end
                    if (dp_idx == InWords - 1) begin
                        in_valid_d = 1'b1;
                        in_last_d  = dp_addr_q[AW-3];
                    end
                end
                2'b01: begin
                    case (dp_off)
                        32'h00: size_sh_d[31:0] = ahb.HWDATAS;
                        32'h04: size_sh_d[CFGSIZEWIDTH-1:32] = ahb.HWDATAS[CFGSIZEWIDTH-33:0];
                        32'h08: scheme_sh_d = ahb.HWDATAS[CFGSCHEMEWIDTH-1:0];
                        32'h0C: begin
                            in_req_en_d  = ahb.HWDATAS[2];
                            out_req_en_d = ahb.HWDATAS[3];
                            if (ahb.HWDATAS[0]) begin
                                cfg_size_d   = size_sh_q;
                                cfg_scheme_d = scheme_sh_q;
                                cfg_last_d   = ahb.HWDATAS[1];
                                cfg_valid_d  = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        fifo_d = fifo_q;
        if (push) fifo_d[wr_ptr_q] = {out_last, out_data};
        wr_ptr_d  = wr_ptr_q + PtrW'(push);
        rd_ptr_d  = rd_ptr_q + PtrW'(pop);
        count_d   = count_q + CntW'(push) - CntW'(pop);
        in_req_d  = in_req_en_q && !in_valid_q;
        out_req_d = out_req_en_q && !empty;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q      <= StOk;
            dp_addr_q    <= '0;
            dp_wr_q      <= 1'b0;
            rdata_q      <= '0;
            in_data_q    <= '0;
            in_valid_q   <= 1'b0;
            in_last_q    <= 1'b0;
            size_sh_q    <= '0;
            scheme_sh_q  <= '0;
            cfg_size_q   <= '0;
            cfg_scheme_q <= '0;
            cfg_last_q   <= 1'b0;
            cfg_valid_q  <= 1'b0;
            in_req_en_q  <= 1'b0;
            out_req_en_q <= 1'b0;
            in_req_q     <= 1'b0;
            out_req_q    <= 1'b0;
            fifo_q       <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            dp_addr_q    <= dp_addr_d;
            dp_wr_q      <= dp_wr_d;
            rdata_q      <= rdata_d;
            in_data_q    <= in_data_d;
            in_valid_q   <= in_valid_d;
            in_last_q    <= in_last_d;
            size_sh_q    <= size_sh_d;
            scheme_sh_q  <= scheme_sh_d;
            cfg_size_q   <= cfg_size_d;
            cfg_scheme_q <= cfg_scheme_d;
            cfg_last_q   <= cfg_last_d;
            cfg_valid_q  <= cfg_valid_d;
            in_req_en_q  <= in_req_en_d;
            out_req_en_q <= out_req_en_d;
            in_req_q     <= in_req_d;
            out_req_q    <= out_req_d;
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    assign ahb.HREADYOUTS = hready;
    assign ahb.HRESPS     = hresp;
    assign ahb.HRDATAS    = rdata_q;
    assign in_data        = in_data_q;
    assign in_last        = in_last_q;
    assign in_valid       = in_valid_q;
    assign cfg_size       = cfg_size_q;
    assign cfg_scheme     = cfg_scheme_q;
    assign cfg_last       = cfg_last_q;
    assign cfg_valid      = cfg_valid_q;
    assign out_ready      = !full;
    assign in_data_req    = in_req_q;
    assign out_data_req   = out_req_q;
endmodule

// File: tb/tb_wrapper_ahb_stream_bridge.sv
// Directed self-checking bench for wrapper_ahb_stream_bridge at default parameters.
module tb_wrapper_ahb_stream_bridge;
    localparam int unsigned AW = 12;

    logic         HCLK = 1'b0;
    logic         HRESET;
    logic [511:0] in_data;
    logic         in_last, in_valid, in_ready;
    logic [63:0]  cfg_size;
    logic [1:0]   cfg_scheme;
    logic         cfg_last, cfg_valid, cfg_ready;
    logic [255:0] out_data;
    logic         out_last, out_valid, out_ready;
    logic         in_data_req, out_data_req;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] rd_v;
    logic        er;
    int          wt;

    always #5 HCLK = ~HCLK;

    wrapper_ahb_stream_bridge_if #(.AHBADDRWIDTH(AW)) ahb ();
    assign ahb.HREADYS = ahb.HREADYOUTS;

    wrapper_ahb_stream_bridge dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .ahb         (ahb),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .cfg_size    (cfg_size),
        .cfg_scheme  (cfg_scheme),
        .cfg_last    (cfg_last),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .in_data_req (in_data_req),
        .out_data_req(out_data_req)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ahb_xfer(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wdata,
                            input logic [2:0] size, output logic [31:0] rdata,
                            output logic err, output int waits);
        ahb.HSELS   = 1'b1;
        ahb.HTRANSS = 2'b10;
        ahb.HADDRS  = addr;
        ahb.HWRITES = wr;
        ahb.HSIZES  = size;
        @(posedge HCLK); #1;
        ahb.HSELS   = 1'b0;
        ahb.HTRANSS = 2'b00;
        ahb.HWRITES = 1'b0;
        ahb.HWDATAS = wr ? wdata : 32'h0;
        waits = 0;
        while (ahb.HREADYOUTS !== 1'b1 && waits < 20) begin
            waits++;
            @(posedge HCLK); #1;
        end
        rdata = ahb.HRDATAS;
        err   = ahb.HRESPS;
        @(posedge HCLK); #1;
    endtask

    task automatic wr(input logic [AW-1:0] addr, input logic [31:0] data);
        logic [31:0] d;
        logic        e;
        int          w;
        ahb_xfer(1'b1, addr, data, 3'b010, d, e, w);
        check("wr_okay", 64'({e, 32'(w)}), 64'h0);
    endtask

    task automatic rd_chk(input string tag, input logic [AW-1:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        int          w;
        ahb_xfer(1'b0, addr, 32'h0, 3'b010, d, e, w);
        check(tag, 64'({e, 32'(w), d}), 64'({1'b0, 32'h0, exp}));
    endtask

    function automatic logic [255:0] pkt(input int k);
        logic [255:0] p;
        for (int j = 0; j < 8; j++) p[j*32 +: 32] = 32'hA000_0000 + 32'(k * 16 + j);
        return p;
    endfunction

    initial begin
        HRESET = 1'b1; in_ready = 1'b0; cfg_ready = 1'b0;
        out_valid = 1'b0; out_last = 1'b0; out_data = '0;
        ahb.HSELS = 1'b0; ahb.HADDRS = '0; ahb.HTRANSS = 2'b00; ahb.HSIZES = 3'b010;
        ahb.HWRITES = 1'b0; ahb.HWDATAS = '0;
        repeat (3) @(posedge HCLK);
        #1 HRESET = 1'b0;

        check("rst_hreadyout", ahb.HREADYOUTS, 1);
        check("rst_hresp", ahb.HRESPS, 0);
        check("rst_hrdata", ahb.HRDATAS, 0);
        check("rst_in", {|in_data, in_last, in_valid}, 0);
        check("rst_cfg", {|cfg_size, |cfg_scheme, cfg_last, cfg_valid}, 0);
        check("rst_out_ready", out_ready, 1);
        check("rst_reqs", {in_data_req, out_data_req}, 0);

        // Input packet, lower half of window
        for (int i = 0; i < 16; i++) wr(AW'(4 * i), 32'h1000_0000 + 32'(i));
        check("pkt1_valid_last", {in_valid, in_last}, 2'b10);
        check("pkt1_word0", in_data[31:0], 32'h1000_0000);
        check("pkt1_word15", in_data[511:480], 32'h1000_000F);
        rd_chk("status_in_valid", 12'h410, 32'h5);
        rd_chk("input_read_zero", 12'h000, 32'h0);
        in_ready = 1'b1;
        @(posedge HCLK); #1;
        in_ready = 1'b0;
        check("pkt1_handshake", in_valid, 0);

        // Upper half marks last; then a write during in_valid stalls
        for (int i = 0; i < 16; i++) wr(12'h200 + AW'(4 * i), 32'h2000_0000 + 32'(i));
        check("pkt2_valid_last", {in_valid, in_last}, 2'b11);
        check("pkt2_word1", in_data[63:32], 32'h2000_0001);
        fork
            ahb_xfer(1'b1, 12'h000, 32'hDEAD_BEEF, 3'b010, rd_v, er, wt);
            begin
                repeat (5) @(posedge HCLK);
                #1 in_ready = 1'b1;
                @(posedge HCLK);
                #1 in_ready = 1'b0;
            end
        join
        check("stall_in_waits", wt, 5);
        check("stall_in_resp", er, 0);
        check("stall_in_valid", in_valid, 0);
        check("stall_in_word0", in_data[31:0], 32'hDEAD_BEEF);
        check("stall_in_word1", in_data[63:32], 32'h2000_0001);

        // Config channel
        wr(12'h400, 32'h200);
        wr(12'h404, 32'h0);
        wr(12'h408, 32'h1);
        rd_chk("size_lo_rb", 12'h400, 32'h200);
        rd_chk("scheme_rb", 12'h408, 32'h1);
        wr(12'h40C, 32'h3);
        check("cfg_valid", cfg_valid, 1);
        check("cfg_size", cfg_size, 64'd512);
        check("cfg_scheme_last", {cfg_scheme, cfg_last}, 3'b011);
        repeat (3) @(posedge HCLK);
        #1 check("cfg_valid_held", cfg_valid, 1);
        rd_chk("status_cfg_valid", 12'h410, 32'h6);
        fork
            ahb_xfer(1'b1, 12'h400, 32'h300, 3'b010, rd_v, er, wt);
            begin
                repeat (2) @(posedge HCLK);
                #1 cfg_ready = 1'b1;
                @(posedge HCLK);
                #1 cfg_ready = 1'b0;
            end
        join
        check("stall_cfg_waits", wt, 2);
        check("stall_cfg_resp", er, 0);
        check("cfg_valid_cleared", cfg_valid, 0);
        check("cfg_size_kept", cfg_size, 64'd512);
        rd_chk("size_lo_new", 12'h400, 32'h300);

        // Output FIFO: three offered, two fit
        out_valid = 1'b1; out_data = pkt(0); out_last = 1'b0;
        @(posedge HCLK); #1;
        out_data = pkt(1); out_last = 1'b1;
        @(posedge HCLK); #1;
        check("fifo_full_ready", out_ready, 0);
        out_data = pkt(2); out_last = 1'b0;
        @(posedge HCLK); #1;
        check("fifo_full_hold", out_ready, 0);
        out_valid = 1'b0;
        rd_chk("status_full", 12'h410, 32'h208);
        for (int j = 0; j < 8; j++) rd_chk("out_pkt0", 12'h800 + AW'(4 * j), 32'hA000_0000 + 32'(j));
        check("fifo_pop_ready", out_ready, 1);
        rd_chk("status_count1", 12'h410, 32'h100);
        out_valid = 1'b1;
        @(posedge HCLK); #1;
        out_valid = 1'b0;
        rd_chk("status_count2", 12'h410, 32'h208);
        rd_chk("head_last", 12'h414, 32'h1);

        // Error responses
        ahb_xfer(1'b1, 12'h400, 32'hFFFF, 3'b000, rd_v, er, wt);
        check("err_byte", {er, 32'(wt)}, {1'b1, 32'd1});
        rd_chk("err_byte_nochange", 12'h400, 32'h300);
        ahb_xfer(1'b0, 12'h402, 32'h0, 3'b010, rd_v, er, wt);
        check("err_unaligned", {er, 32'(wt)}, {1'b1, 32'd1});
        ahb_xfer(1'b1, 12'h800, 32'h1234, 3'b010, rd_v, er, wt);
        check("err_out_write", {er, 32'(wt)}, {1'b1, 32'd1});
        rd_chk("err_out_nochange", 12'h410, 32'h208);
        for (int j = 0; j < 8; j++) rd_chk("out_pkt1", 12'h800 + AW'(4 * j), 32'hA000_0010 + 32'(j));
        for (int j = 0; j < 8; j++) rd_chk("out_pkt2", 12'h800 + AW'(4 * j), 32'hA000_0020 + 32'(j));
        rd_chk("status_empty", 12'h410, 32'h4);
        ahb_xfer(1'b0, 12'h800, 32'h0, 3'b010, rd_v, er, wt);
        check("err_empty_read", {er, 32'(wt)}, {1'b1, 32'd1});
        rd_chk("status_empty_kept", 12'h410, 32'h4);

        // DMA requests lag their conditions by one cycle
        wr(12'h40C, 32'hC);
        check("in_req_lag", in_data_req, 0);
        @(posedge HCLK); #1;
        check("in_req_set", {in_data_req, out_data_req}, 2'b10);
        rd_chk("ctrl_rb", 12'h40C, 32'hC);
        out_valid = 1'b1; out_data = pkt(3); out_last = 1'b1;
        @(posedge HCLK); #1;
        out_valid = 1'b0;
        check("out_req_lag", out_data_req, 0);
        @(posedge HCLK); #1;
        check("out_req_set", out_data_req, 1);
        wr(12'h03C, 32'h55);
        check("in_req_before_drop", {in_valid, in_data_req}, 2'b11);
        @(posedge HCLK); #1;
        check("in_req_drop", in_data_req, 0);

        // Reset in the middle of a packet
        in_ready = 1'b1;
        @(posedge HCLK); #1;
        in_ready = 1'b0;
        wr(12'h000, 32'h77);
        wr(12'h004, 32'h88);
        #2 HRESET = 1'b1;
        #3 HRESET = 1'b0;
        @(posedge HCLK); #1;
        check("mid_rst_in", {|in_data, in_valid, in_last}, 0);
        check("mid_rst_cfg", {|cfg_size, cfg_valid, cfg_last}, 0);
        check("mid_rst_outs", {out_ready, in_data_req, out_data_req, ahb.HREADYOUTS, ahb.HRESPS},
              5'b10010);
        rd_chk("mid_rst_status", 12'h410, 32'h4);
        rd_chk("mid_rst_ctrl", 12'h40C, 32'h0);
        rd_chk("mid_rst_shadow", 12'h400, 32'h0);
        wr(12'h03C, 32'h99);
        check("no_partial_valid", in_valid, 1);
        check("no_partial_word0", in_data[31:0], 32'h0);
        check("no_partial_word15", in_data[511:480], 32'h99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
